// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths and scheduler state type for the Fibonacci front-end
package fib_pkg;

    localparam int LEVEL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } fib_sched_state_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fib_req_fifo.sv
// rtl/fib_req_fifo.sv - synchronous request FIFO with full/empty flags
module fib_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push is refused while full even if the same cycle pops.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_req_scheduler.sv
// rtl/fib_req_scheduler.sv - queues tagged requests, drives the Fibonacci core one at a time, returns tagged responses
module fib_req_scheduler
    import fib_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [LEVEL_W-1:0] i_req_level,
    input  logic [TAG_W-1:0]   i_req_tag,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [LEVEL_W-1:0] o_rsp_result,
    output logic [TAG_W-1:0]   o_rsp_tag,
    output logic               o_rsp_err,
    output logic               o_core_in_valid,
    output logic [LEVEL_W-1:0] o_core_in_level,
    input  logic               i_core_out_valid,
    input  logic [LEVEL_W-1:0] i_core_result,
    output logic               o_busy
);

    localparam int ENTRY_W = LEVEL_W + TAG_W;
    localparam int CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fib_sched_state_t r_state;
    fib_sched_state_t w_state_nxt;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_capture;
    logic               w_timeout;
    logic               w_rsp_fire;
    logic [ENTRY_W-1:0] w_head;
    logic [LEVEL_W-1:0] w_head_level;
    logic [TAG_W-1:0]   w_head_tag;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic [LEVEL_W-1:0] r_level;
    logic [TAG_W-1:0]   r_tag;
    logic [LEVEL_W-1:0] r_result;
    logic               r_err;
    logic               r_rsp_valid;
    logic [CNT_W-1:0]   r_cnt;

    fib_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_req_valid),
        .i_wdata ({i_req_level, i_req_tag}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_level, w_head_tag} = w_head;
    assign w_rsp_fire = r_rsp_valid && i_rsp_ready;
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    // Level 0 is answered locally; the core never sees it.
                    w_state_nxt = (w_head_level == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_core_out_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // r_cnt counts cycles since ISSUE began, so the timeout response rises TIMEOUT cycles after the core start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level     <= '0;
            r_tag       <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_pop) begin
                r_level  <= w_head_level;
                r_tag    <= w_head_tag;
                r_result <= '0;
                r_err    <= 1'b0;
                r_cnt    <= '0;
            end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_capture) begin
                r_result <= i_core_result;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            r_rsp_valid <= (r_state == ST_RESP) && !w_rsp_fire;
        end
    end

    assign o_req_ready     = !w_full;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_result    = r_result;
    assign o_rsp_tag       = r_tag;
    assign o_rsp_err       = r_err;
    assign o_core_in_valid = (r_state == ST_ISSUE);
    assign o_core_in_level = r_level;
    assign o_busy          = (r_state != ST_IDLE) || !w_empty;

endmodule
